// File: rtl/sonic_eth_10g_link_fault_status_source.sv
// sonic_eth_10g_link_fault_status_source
// RX reconciliation-sublayer link fault detector for the 10G MAC. Scans the
// 64-bit SDR XGMII receive stream (two columns per clk) for local/remote fault
// Sequence ordered sets and publishes the 2-bit link fault status as an
// Avalon-ST source.
//
// Ports:
//   clk, reset_n      156.25 MHz XGMII RX clock, async active-low reset
//   xgmii_rx_data     64b, column0 = [31:0] (lane0 = [7:0]), column1 = [63:32]
//   xgmii_rx_ctrl     8b, bit i qualifies data byte i
//   out_valid/out_data/out_ready   Avalon-ST status source (00 OK, 01 local, 10 remote)
//   link_fault        live internal status, same encoding
//
// Optional build macro LINK_FAULT_STATS_EN adds:
//   stat_clear        in, synchronous clear of both counters (wins over increment)
//   stat_local_cnt    out 16b, saturating count of entries into local fault
//   stat_remote_cnt   out 16b, saturating count of entries into remote fault

module sonic_eth_10g_link_fault_status_source #(
    parameter int unsigned COL_WINDOW    = 128,
    parameter int unsigned SEQ_THRESHOLD = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [63:0] xgmii_rx_data,
    input  logic [7:0]  xgmii_rx_ctrl,
    output logic        out_valid,
    output logic [1:0]  out_data,
    input  logic        out_ready,
    output logic [1:0]  link_fault
`ifdef LINK_FAULT_STATS_EN
    ,
    input  logic        stat_clear,
    output logic [15:0] stat_local_cnt,
    output logic [15:0] stat_remote_cnt
`endif
);

    localparam int unsigned CNT_W     = $clog2(COL_WINDOW) + 1;
    localparam logic [1:0]  LF_OK     = 2'b00;
    localparam logic [1:0]  LF_LOCAL  = 2'b01;
    localparam logic [1:0]  LF_REMOTE = 2'b10;

    logic [CNT_W-1:0] col_cnt_q, col_cnt_d;
    logic [3:0]       seq_cnt_q, seq_cnt_d;
    logic [1:0]       seq_type_q, seq_type_d;
    logic [1:0]       link_fault_q, link_fault_d;
    logic [1:0]       sent_status_q, sent_status_d;
    logic             out_valid_q, out_valid_d;
    logic [1:0]       out_data_q, out_data_d;

    logic [31:0]      col_word;
    logic [3:0]       col_ctrl;
    logic             col_is_fault;
    logic [1:0]       col_type;

    // Fault sequence detection; column1 is evaluated on column0's updated state.
    always_comb begin
        col_cnt_d    = col_cnt_q;
        seq_cnt_d    = seq_cnt_q;
        seq_type_d   = seq_type_q;
        link_fault_d = link_fault_q;
        col_word     = 32'h0;
        col_ctrl     = 4'h0;
        col_is_fault = 1'b0;
        col_type     = LF_OK;
        for (int c = 0; c < 2; c++) begin
            col_word     = xgmii_rx_data[32*c +: 32];
            col_ctrl     = xgmii_rx_ctrl[4*c +: 4];
            col_is_fault = (col_ctrl == 4'b0001) && (col_word[7:0] == 8'h9C) &&
                           (col_word[23:8] == 16'h0000) &&
                           ((col_word[31:24] == 8'h01) || (col_word[31:24] == 8'h02));
            col_type     = (col_word[31:24] == 8'h01) ? LF_LOCAL : LF_REMOTE;
            if (col_is_fault) begin
                col_cnt_d = '0;
                if (col_type != seq_type_d) begin
                    seq_type_d = col_type;
                    seq_cnt_d  = 4'd1;
                end else if (seq_cnt_d < 4'(SEQ_THRESHOLD - 1)) begin
                    seq_cnt_d = seq_cnt_d + 4'd1;
                end else begin
                    link_fault_d = col_type;
                end
            end else if (col_cnt_d == CNT_W'(COL_WINDOW - 1)) begin
                seq_cnt_d    = 4'd0;
                link_fault_d = LF_OK;
                col_cnt_d    = '0;
            end else begin
                col_cnt_d = col_cnt_d + CNT_W'(1);
            end
        end
    end

    // Avalon-ST source: hold data while stalled, re-compare one clk after acceptance.
    always_comb begin
        out_valid_d   = out_valid_q;
        out_data_d    = out_data_q;
        sent_status_d = sent_status_q;
        if (out_valid_q) begin
            if (out_ready) begin
                sent_status_d = out_data_q;
                out_valid_d   = 1'b0;
            end
        end else if (link_fault_q != sent_status_q) begin
            out_valid_d = 1'b1;
            out_data_d  = link_fault_q;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            col_cnt_q     <= '0;
            seq_cnt_q     <= 4'd0;
            seq_type_q    <= LF_OK;
            link_fault_q  <= LF_OK;
            sent_status_q <= LF_OK;
            out_valid_q   <= 1'b0;
            out_data_q    <= 2'b00;
        end else begin
            col_cnt_q     <= col_cnt_d;
            seq_cnt_q     <= seq_cnt_d;
            seq_type_q    <= seq_type_d;
            link_fault_q  <= link_fault_d;
            sent_status_q <= sent_status_d;
            out_valid_q   <= out_valid_d;
            out_data_q    <= out_data_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign link_fault = link_fault_q;

`ifdef LINK_FAULT_STATS_EN
    logic [15:0] stat_local_q, stat_local_d;
    logic [15:0] stat_remote_q, stat_remote_d;

    // Count entries into each fault state, saturating; clear has priority.
    always_comb begin
        stat_local_d  = stat_local_q;
        stat_remote_d = stat_remote_q;
        if (stat_clear) begin
            stat_local_d  = 16'h0000;
            stat_remote_d = 16'h0000;
        end else begin
            if ((link_fault_d == LF_LOCAL) && (link_fault_q != LF_LOCAL) &&
                (stat_local_q != 16'hFFFF)) begin
                stat_local_d = stat_local_q + 16'd1;
            end
            if ((link_fault_d == LF_REMOTE) && (link_fault_q != LF_REMOTE) &&
                (stat_remote_q != 16'hFFFF)) begin
                stat_remote_d = stat_remote_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stat_local_q  <= 16'h0000;
            stat_remote_q <= 16'h0000;
        end else begin
            stat_local_q  <= stat_local_d;
            stat_remote_q <= stat_remote_d;
        end
    end

    assign stat_local_cnt  = stat_local_q;
    assign stat_remote_cnt = stat_remote_q;
`endif

endmodule

// File: tb/tb_sonic_eth_10g_link_fault_status_source.sv
// Directed bench for sonic_eth_10g_link_fault_status_source. Expected status
// updates are queued by the stimulus; a negedge monitor pops one per accepted
// transfer and also checks that data stays stable while the sink stalls.
module tb_sonic_eth_10g_link_fault_status_source;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [63:0] xgmii_rx_data;
    logic [7:0]  xgmii_rx_ctrl;
    logic        out_valid;
    logic [1:0]  out_data;
    logic        out_ready;
    logic [1:0]  link_fault;
`ifdef LINK_FAULT_STATS_EN
    logic        stat_clear;
    logic [15:0] stat_local_cnt;
    logic [15:0] stat_remote_cnt;
`endif

    // Column = {ctrl[3:0], data[31:0]}
    localparam logic [35:0] IDLE_COL   = {4'hF, 32'h07070707};
    localparam logic [35:0] LOCAL_COL  = {4'b0001, 32'h0100009C};
    localparam logic [35:0] REMOTE_COL = {4'b0001, 32'h0200009C};

    int n_cmp = 0;
    int n_err = 0;
    logic [1:0] exp_q[$];
    logic       prev_stall = 1'b0;
    logic [1:0] prev_data  = 2'b00;

    sonic_eth_10g_link_fault_status_source dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .xgmii_rx_data (xgmii_rx_data),
        .xgmii_rx_ctrl (xgmii_rx_ctrl),
        .out_valid     (out_valid),
        .out_data      (out_data),
        .out_ready     (out_ready),
        .link_fault    (link_fault)
`ifdef LINK_FAULT_STATS_EN
        ,
        .stat_clear      (stat_clear),
        .stat_local_cnt  (stat_local_cnt),
        .stat_remote_cnt (stat_remote_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc(input logic [35:0] c0, input logic [35:0] c1);
        xgmii_rx_data = {c1[31:0], c0[31:0]};
        xgmii_rx_ctrl = {c1[35:32], c0[35:32]};
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(IDLE_COL, IDLE_COL);
    endtask

    // Four fresh local sequences in column0 -> local fault.
    task automatic four_local();
        for (int i = 0; i < 4; i++) cyc(LOCAL_COL, IDLE_COL);
    endtask

    // Monitor: each accepted transfer must match the next queued status.
    always @(negedge clk) begin
        if (reset_n && out_valid) begin
            if (prev_stall) chk("held_data", 32'(out_data), 32'(prev_data));
            if (out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_update", 32'(out_data), 32'hFFFF_FFFF);
                end else begin
                    chk("update_data", 32'(out_data), 32'(exp_q.pop_front()));
                end
            end
        end
        prev_stall = reset_n && out_valid && !out_ready;
        prev_data  = out_data;
    end

    initial begin
        int saw;
        reset_n       = 1'b0;
        out_ready     = 1'b1;
        xgmii_rx_data = {2{32'h07070707}};
        xgmii_rx_ctrl = 8'hFF;
`ifdef LINK_FAULT_STATS_EN
        stat_clear    = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_data", 32'(out_data), 32'd0);
        chk("rst_lf", 32'(link_fault), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // Idle stream never raises a status update.
        saw = 0;
        for (int i = 0; i < 1000; i++) begin
            cyc(IDLE_COL, IDLE_COL);
            if (out_valid) saw++;
        end
        chk("idle_no_valid", 32'(saw), 32'd0);
        chk("idle_lf", 32'(link_fault), 32'd0);

        // Four local sequences, one per clk.
        exp_q.push_back(2'b01);
        for (int i = 0; i < 3; i++) cyc(LOCAL_COL, IDLE_COL);
        chk("lf_after3", 32'(link_fault), 32'd0);
        cyc(LOCAL_COL, IDLE_COL);
        chk("lf_after4", 32'(link_fault), 32'd1);
        chk("valid_lat0", 32'(out_valid), 32'd0);
        cyc(IDLE_COL, IDLE_COL);
        chk("valid_lat1", 32'(out_valid), 32'd1);
        chk("data_lat1", 32'(out_data), 32'd1);

        // Window boundary: refresh at column 127 keeps fault, 128 idle columns clear it.
        cyc(IDLE_COL, LOCAL_COL);
        idle(63);
        cyc(IDLE_COL, LOCAL_COL);
        chk("win_refresh", 32'(link_fault), 32'd1);
        idle(63);
        chk("win_126", 32'(link_fault), 32'd1);
        exp_q.push_back(2'b00);
        idle(1);
        chk("win_128", 32'(link_fault), 32'd0);
        idle(4);

        // Stalled sink: data holds at 01 while status moves to remote.
        out_ready = 1'b0;
        exp_q.push_back(2'b01);
        four_local();
        idle(20);
        chk("stall_valid", 32'(out_valid), 32'd1);
        chk("stall_data", 32'(out_data), 32'd1);
        exp_q.push_back(2'b10);
        for (int i = 0; i < 4; i++) cyc(REMOTE_COL, IDLE_COL);
        chk("stall_lf_remote", 32'(link_fault), 32'd2);
        chk("stall_data_held", 32'(out_data), 32'd1);
        out_ready = 1'b1;
        idle(1);
        chk("gap_valid", 32'(out_valid), 32'd0);
        idle(1);
        chk("next_valid", 32'(out_valid), 32'd1);
        chk("next_data", 32'(out_data), 32'd2);
        idle(2);

        // Back to OK, then alternating types in one clk never build up a count.
        exp_q.push_back(2'b00);
        idle(70);
        chk("ok_again", 32'(link_fault), 32'd0);
        for (int i = 0; i < 4; i++) cyc(LOCAL_COL, REMOTE_COL);
        chk("alt_lf", 32'(link_fault), 32'd0);
        // seq_cnt = 1 remote, so three more remote sequences complete the fault.
        exp_q.push_back(2'b10);
        cyc(REMOTE_COL, IDLE_COL);
        cyc(REMOTE_COL, IDLE_COL);
        chk("alt_after2", 32'(link_fault), 32'd0);
        cyc(REMOTE_COL, IDLE_COL);
        chk("alt_after3", 32'(link_fault), 32'd2);
        idle(4);

        // Reset while an update is stalled drops it.
        out_ready = 1'b0;
        idle(70);
        chk("pre_rst_valid", 32'(out_valid), 32'd1);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_lf", 32'(link_fault), 32'd0);
        @(negedge clk);
        reset_n   = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        saw = 0;
        for (int i = 0; i < 20; i++) begin
            cyc(IDLE_COL, IDLE_COL);
            if (out_valid) saw++;
        end
        chk("post_rst_quiet", 32'(saw), 32'd0);
        exp_q.push_back(2'b01);
        four_local();
        chk("post_rst_fault", 32'(link_fault), 32'd1);
        idle(4);

`ifdef LINK_FAULT_STATS_EN
        stat_clear = 1'b1;
        idle(1);
        stat_clear = 1'b0;
        chk("stat_clr0", 32'(stat_local_cnt), 32'd0);
        for (int r = 0; r < 3; r++) begin
            exp_q.push_back(2'b00);
            idle(70);
            exp_q.push_back(2'b01);
            four_local();
        end
        idle(4);
        chk("stat_local3", 32'(stat_local_cnt), 32'd3);
        chk("stat_remote0", 32'(stat_remote_cnt), 32'd0);
        stat_clear = 1'b1;
        idle(1);
        stat_clear = 1'b0;
        chk("stat_clr1", 32'(stat_local_cnt), 32'd0);
`endif

        idle(4);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
